// File: rtl/voter_pkg.sv
// Shared constants for the TMR voter: FSM state encodings, replica bit
// positions within the rep_bad mask, and a small helper.
package voter_pkg;

  // Voter FSM state encodings, visible on the voter_state output.
  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_DEGRADED = 2'd1;
  localparam logic [1:0] ST_FAILED   = 2'd2;
  localparam logic [1:0] ST_RESYNC   = 2'd3;

  // Replica bit positions in rep_bad and in per-replica fault vectors.
  localparam int REP_A = 0;
  localparam int REP_B = 1;
  localparam int REP_C = 2;

  // Number of replicas currently flagged in a 3-bit mask.
  function automatic logic [1:0] popcount3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage

// File: rtl/voter_field_cmp.sv
// Majority compare for a single voted field. Masked replicas take no part
// in the vote; with one replica masked the remaining two must agree, with
// two or more masked no majority can be formed. diff_o flags every unmasked
// replica that disagrees with the majority (only meaningful when ok_o=1).
module voter_field_cmp
  import voter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [2:0]       mask_i,
  output logic [WIDTH-1:0] maj_o,
  output logic             ok_o,
  output logic [2:0]       diff_o
);

  // Pick the majority word for this field and flag disagreeing replicas.
  always_comb begin
    maj_o  = '0;
    ok_o   = 1'b0;
    diff_o = 3'b000;
    case (mask_i)
      3'b000: begin
        if (a_i == b_i || a_i == c_i) begin
          maj_o = a_i;
          ok_o  = 1'b1;
        end else if (b_i == c_i) begin
          maj_o = b_i;
          ok_o  = 1'b1;
        end
      end
      3'b001: begin
        if (b_i == c_i) begin
          maj_o = b_i;
          ok_o  = 1'b1;
        end
      end
      3'b010: begin
        if (a_i == c_i) begin
          maj_o = a_i;
          ok_o  = 1'b1;
        end
      end
      3'b100: begin
        if (a_i == b_i) begin
          maj_o = a_i;
          ok_o  = 1'b1;
        end
      end
      default: begin
        ok_o = 1'b0;
      end
    endcase
    if (ok_o) begin
      diff_o[REP_A] = !mask_i[REP_A] && (a_i != maj_o);
      diff_o[REP_B] = !mask_i[REP_B] && (b_i != maj_o);
      diff_o[REP_C] = !mask_i[REP_C] && (c_i != maj_o);
    end
  end

endmodule

// File: rtl/voter_tmr_param.sv
// Parameterised TMR voter. Votes NFIELD fields of three replicas each cycle
// vote_en is high, registers the voted word, tracks consecutive and lifetime
// faults per replica, masks replicas that stay faulty, and runs a small
// health FSM that requests a resync from an external controller.
// Handshake: resync_req is a level that stays high while the voter is
// DEGRADED or FAILED; the controller answers by raising resync_ack, which is
// sampled on a clock edge and moves the voter into RESYNC for one cycle.
module voter_tmr_param
  import voter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NFIELD   = 4,
  parameter int FAULT_TH = 3,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    vote_en,
  input  logic [WIDTH*NFIELD-1:0] in_a,
  input  logic [WIDTH*NFIELD-1:0] in_b,
  input  logic [WIDTH*NFIELD-1:0] in_c,
  output logic [WIDTH*NFIELD-1:0] vote_out,
  output logic                    vote_valid,
  output logic                    err_uncorr,
  output logic [2:0]              rep_bad,
  output logic [CNT_W-1:0]        err_cnt_a,
  output logic [CNT_W-1:0]        err_cnt_b,
  output logic [CNT_W-1:0]        err_cnt_c,
  output logic [1:0]              voter_state,
  output logic                    resync_req,
  input  logic                    resync_ack
);

  localparam int TW = (FAULT_TH < 1) ? 1 : $clog2(FAULT_TH + 1);
  localparam logic [TW-1:0] TH = TW'(FAULT_TH);

  logic [WIDTH*NFIELD-1:0] maj_word;
  logic [NFIELD-1:0]       field_ok;
  logic [2:0]              field_diff [NFIELD];

  logic                    uncorr;
  logic [2:0]              faulty;
  logic                    vote_act;

  logic [1:0]              state_q,   state_d;
  logic [WIDTH*NFIELD-1:0] out_q,     out_d;
  logic                    valid_q,   valid_d;
  logic                    uncorr_q,  uncorr_d;
  logic [2:0]              bad_q,     bad_d;
  logic [TW-1:0]           cons_q [3];
  logic [TW-1:0]           cons_d [3];
  logic [CNT_W-1:0]        err_q  [3];
  logic [CNT_W-1:0]        err_d  [3];

  for (genvar k = 0; k < NFIELD; k++) begin : g_field
    voter_field_cmp #(
      .WIDTH (WIDTH)
    ) u_cmp (
      .a_i    (in_a[k*WIDTH +: WIDTH]),
      .b_i    (in_b[k*WIDTH +: WIDTH]),
      .c_i    (in_c[k*WIDTH +: WIDTH]),
      .mask_i (bad_q),
      .maj_o  (maj_word[k*WIDTH +: WIDTH]),
      .ok_o   (field_ok[k]),
      .diff_o (field_diff[k])
    );
  end

  // Fold per-field results: any field without a majority spoils the vote,
  // and a replica is faulty if it disagrees in any field.
  always_comb begin
    uncorr = ~&field_ok;
    faulty = 3'b000;
    for (int k = 0; k < NFIELD; k++) begin
      faulty = faulty | field_diff[k];
    end
  end

  // Votes are ignored for the single RESYNC cycle.
  assign vote_act = vote_en && (state_q != ST_RESYNC);

  // Next-state: vote result, fault counters, replica mask and FSM.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    uncorr_d = uncorr_q;
    bad_d    = bad_q;
    cons_d   = cons_q;
    err_d    = err_q;

    if (vote_act) begin
      uncorr_d = uncorr;
      if (!uncorr) begin
        out_d   = maj_word;
        valid_d = 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        if (!bad_q[r]) begin
          if (faulty[r]) begin
            if (cons_q[r] < TH) cons_d[r] = cons_q[r] + 1'b1;
            if (err_q[r] != '1) err_d[r] = err_q[r] + 1'b1;
            if (cons_d[r] >= TH) bad_d[r] = 1'b1;
          end else begin
            cons_d[r] = '0;
          end
        end
      end
    end

    case (state_q)
      ST_NORMAL: begin
        if ((vote_act && uncorr) || popcount3(bad_d) >= 2'd2) begin
          state_d = ST_FAILED;
        end else if (popcount3(bad_d) == 2'd1) begin
          state_d = ST_DEGRADED;
        end
      end
      ST_DEGRADED: begin
        if ((vote_act && uncorr) || popcount3(bad_d) >= 2'd2) begin
          state_d = ST_FAILED;
        end else if (resync_ack) begin
          state_d = ST_RESYNC;
        end
      end
      ST_FAILED: begin
        if (resync_ack) state_d = ST_RESYNC;
      end
      default: begin
        state_d = ST_NORMAL;
        bad_d   = 3'b000;
        for (int r = 0; r < 3; r++) cons_d[r] = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q  <= ST_NORMAL;
      out_q    <= '0;
      valid_q  <= 1'b0;
      uncorr_q <= 1'b0;
      bad_q    <= 3'b000;
      for (int r = 0; r < 3; r++) begin
        cons_q[r] <= '0;
        err_q[r]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      uncorr_q <= uncorr_d;
      bad_q    <= bad_d;
      for (int r = 0; r < 3; r++) begin
        cons_q[r] <= cons_d[r];
        err_q[r]  <= err_d[r];
      end
    end
  end

  assign vote_out    = out_q;
  assign vote_valid  = valid_q;
  assign err_uncorr  = uncorr_q;
  assign rep_bad     = bad_q;
  assign err_cnt_a   = err_q[REP_A];
  assign err_cnt_b   = err_q[REP_B];
  assign err_cnt_c   = err_q[REP_C];
  assign voter_state = state_q;
  assign resync_req  = (state_q == ST_DEGRADED) || (state_q == ST_FAILED);

endmodule

// File: tb/tb_voter_tmr_param.sv
// Directed bench for voter_tmr_param with default parameters
// (WIDTH=32, NFIELD=4, FAULT_TH=3, CNT_W=8).
module tb_voter_tmr_param;

  localparam int W = 128;

  logic         clk;
  logic         rst_in;
  logic         vote_en;
  logic [W-1:0] in_a, in_b, in_c;
  logic [W-1:0] vote_out;
  logic         vote_valid;
  logic         err_uncorr;
  logic [2:0]   rep_bad;
  logic [7:0]   err_cnt_a, err_cnt_b, err_cnt_c;
  logic [1:0]   voter_state;
  logic         resync_req;
  logic         resync_ack;

  int total;
  int bad;

  logic [W-1:0] w1234, wbeef, wb_dead, w55, wa_bad, wone, wtwo, wthree;

  voter_tmr_param dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .vote_en     (vote_en),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_c        (in_c),
    .vote_out    (vote_out),
    .vote_valid  (vote_valid),
    .err_uncorr  (err_uncorr),
    .rep_bad     (rep_bad),
    .err_cnt_a   (err_cnt_a),
    .err_cnt_b   (err_cnt_b),
    .err_cnt_c   (err_cnt_c),
    .voter_state (voter_state),
    .resync_req  (resync_req),
    .resync_ack  (resync_ack)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c);
    vote_en = en;
    in_a    = a;
    in_b    = b;
    in_c    = c;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    w1234   = {4{32'h0000_1234}};
    wbeef   = {4{32'h0000_BEEF}};
    wb_dead = {32'h0000_BEEF, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_BEEF};
    w55     = {4{32'h0000_0055}};
    wa_bad  = {32'h0000_0055, 32'h0000_0055, 32'h0000_0055, 32'h0000_0066};
    wone    = {4{32'h0000_0001}};
    wtwo    = {4{32'h0000_0002}};
    wthree  = {4{32'h0000_0003}};

    rst_in     = 1'b0;
    resync_ack = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();
    step();
    check("rst_vote_out", vote_out, '0);
    check("rst_valid", W'(vote_valid), W'(0));
    check("rst_state", W'(voter_state), W'(0));
    check("rst_rep_bad", W'(rep_bad), W'(0));
    check("rst_req", W'(resync_req), W'(0));
    check("rst_uncorr", W'(err_uncorr), W'(0));
    rst_in = 1'b1;

    // All replicas agree for 5 votes.
    drive(1'b1, w1234, w1234, w1234);
    for (int i = 0; i < 5; i++) begin
      step();
      check("agree_valid", W'(vote_valid), W'(1));
    end
    check("agree_out", vote_out, w1234);
    check("agree_state", W'(voter_state), W'(0));
    check("agree_cnts", W'({err_cnt_a, err_cnt_b, err_cnt_c}), W'(0));
    drive(1'b0, '0, '0, '0);
    step();
    check("idle_valid", W'(vote_valid), W'(0));
    check("idle_hold", vote_out, w1234);

    // Replica B wrong in field 2 for 3 consecutive votes.
    drive(1'b1, wbeef, wb_dead, wbeef);
    step();
    check("b1_rep_bad", W'(rep_bad), W'(0));
    check("b1_cnt_b", W'(err_cnt_b), W'(1));
    check("b1_state", W'(voter_state), W'(0));
    step();
    check("b2_rep_bad", W'(rep_bad), W'(0));
    step();
    check("b3_out", vote_out, wbeef);
    check("b3_valid", W'(vote_valid), W'(1));
    check("b3_rep_bad", W'(rep_bad), W'(3'b010));
    check("b3_state", W'(voter_state), W'(1));
    check("b3_req", W'(resync_req), W'(1));
    check("b3_cnt_b", W'(err_cnt_b), W'(3));
    check("b3_cnt_a", W'(err_cnt_a), W'(0));

    // B masked, A and C disagree: uncorrectable.
    drive(1'b1, wone, wthree, wtwo);
    step();
    check("unc_flag", W'(err_uncorr), W'(1));
    check("unc_valid", W'(vote_valid), W'(0));
    check("unc_hold", vote_out, wbeef);
    check("unc_state", W'(voter_state), W'(2));
    check("unc_cnt_b", W'(err_cnt_b), W'(3));
    drive(1'b0, '0, '0, '0);
    step();
    check("unc_sticky", W'(err_uncorr), W'(1));
    check("failed_req", W'(resync_req), W'(1));

    // Resync handshake; a vote offered during RESYNC must be ignored.
    resync_ack = 1'b1;
    step();
    check("rs_state", W'(voter_state), W'(3));
    check("rs_req", W'(resync_req), W'(0));
    resync_ack = 1'b0;
    drive(1'b1, wone, wtwo, wthree);
    step();
    check("rs_done_state", W'(voter_state), W'(0));
    check("rs_rep_bad", W'(rep_bad), W'(0));
    check("rs_valid", W'(vote_valid), W'(0));
    check("rs_cnt_b", W'(err_cnt_b), W'(3));

    // A faulty twice, one clean, faulty twice: never reaches threshold.
    drive(1'b1, wa_bad, w55, w55);
    step();
    step();
    drive(1'b1, w55, w55, w55);
    step();
    drive(1'b1, wa_bad, w55, w55);
    step();
    step();
    check("cons_rep_bad", W'(rep_bad), W'(0));
    check("cons_cnt_a", W'(err_cnt_a), W'(4));
    check("cons_state", W'(voter_state), W'(0));
    check("cons_out", vote_out, w55);
    check("cons_uncorr", W'(err_uncorr), W'(0));

    // No majority in NORMAL -> FAILED, then RESYNC, then reset inside RESYNC.
    drive(1'b1, wone, wtwo, wthree);
    step();
    check("n_fail_state", W'(voter_state), W'(2));
    drive(1'b0, '0, '0, '0);
    resync_ack = 1'b1;
    step();
    check("n_rs_state", W'(voter_state), W'(3));
    rst_in = 1'b0;
    drive(1'b1, w55, w55, w55);
    step();
    check("rr_state", W'(voter_state), W'(0));
    check("rr_out", vote_out, '0);
    check("rr_valid", W'(vote_valid), W'(0));
    check("rr_uncorr", W'(err_uncorr), W'(0));
    check("rr_rep_bad", W'(rep_bad), W'(0));
    check("rr_cnts", W'({err_cnt_a, err_cnt_b, err_cnt_c}), W'(0));
    check("rr_req", W'(resync_req), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
